// File: rtl/decode_stage.sv
// decode_stage: registered ID/EX decode/control stage with a valid/ready
// handshake on both sides, a load-use interlock, a flush input and a sticky
// HALTED state that only reset leaves.
// Build option: define DECODE_LOAD_USE_INTERLOCK_EN to include the load-use
// interlock (shadow load tracker plus hazard detection). Without it the stage
// never stalls for register dependences.
module decode_stage #(
    parameter int XLEN    = 32,
    parameter int PC_W    = 32,
    parameter int PC_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_alu_op,
    output logic            out_alu_src_imm,
    output logic            out_reg_wrenable,
    output logic            out_mem_wrenable,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_jalr,
    output logic            out_halt,
    output logic [1:0]      out_wb_sel,
    output logic [PC_W-1:0] out_link_pc,
    output logic            halted
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_HALT   = 7'b1111111;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t r_state;
    logic   r_halted;

    // ID/EX output register
    logic            r_valid;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs1, r_rs2, r_rd, r_alu_op;
    logic            r_alu_src_imm, r_reg_we, r_mem_we, r_branch, r_jump, r_jalr, r_halt;
    logic [1:0]      r_wb_sel;
    logic [PC_W-1:0] r_link_pc;

    // instruction fields and decode results
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j;
    logic [XLEN-1:0] w_imm;
    logic [4:0]      w_alu_op;
    logic            w_alu_src_imm, w_reg_we_raw, w_reg_we, w_mem_we;
    logic            w_branch, w_jump, w_jalr, w_halt;
    logic [1:0]      w_wb_sel;
    logic [PC_W-1:0] w_link_pc;
    logic            w_hazard, w_accept, w_xfer;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign w_rs1    = in_instr[19:15];
    assign w_rs2    = in_instr[24:20];
    assign w_rd     = in_instr[11:7];

    assign w_imm_i = {{(XLEN-11){in_instr[31]}}, in_instr[30:20]};
    assign w_imm_s = {{(XLEN-11){in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
    assign w_imm_b = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_j = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    assign w_link_pc = in_pc + PC_W'(PC_STEP);

    // opcode decode into control flags and the selected immediate
    always_comb begin
        w_imm         = {XLEN{1'b0}};
        w_alu_op      = 5'd0;
        w_alu_src_imm = 1'b0;
        w_reg_we_raw  = 1'b0;
        w_mem_we      = 1'b0;
        w_branch      = 1'b0;
        w_jump        = 1'b0;
        w_jalr        = 1'b0;
        w_halt        = 1'b0;
        w_wb_sel      = 2'd0;
        case (w_opcode)
            OP_LOAD: begin
                w_imm         = w_imm_i;
                w_alu_src_imm = 1'b1;
                w_reg_we_raw  = 1'b1;
                w_wb_sel      = 2'd1;
            end
            OP_STORE: begin
                w_imm         = w_imm_s;
                w_alu_src_imm = 1'b1;
                w_mem_we      = 1'b1;
            end
            OP_ITYPE: begin
                w_imm         = w_imm_i;
                w_alu_src_imm = 1'b1;
                w_reg_we_raw  = 1'b1;
                w_alu_op      = {2'b00, w_funct3};
            end
            OP_RTYPE: begin
                w_reg_we_raw  = 1'b1;
                w_alu_op      = {in_instr[30], in_instr[25], w_funct3};
            end
            OP_BRANCH: begin
                w_imm         = w_imm_b;
                w_branch      = 1'b1;
                w_alu_op      = 5'b10000;
            end
            OP_JAL: begin
                w_imm         = w_imm_j;
                w_jump        = 1'b1;
                w_reg_we_raw  = 1'b1;
                w_wb_sel      = 2'd2;
            end
            OP_JALR: begin
                w_imm         = w_imm_i;
                w_jalr        = 1'b1;
                w_alu_src_imm = 1'b1;
                w_reg_we_raw  = 1'b1;
                w_wb_sel      = 2'd2;
            end
            OP_HALT: begin
                w_halt        = 1'b1;
            end
            default: begin
                // unknown opcodes travel down the pipe as a NOP
                w_halt        = 1'b0;
            end
        endcase
    end

    // writes to x0 are architecturally discarded, so never request them
    assign w_reg_we = w_reg_we_raw & (w_rd != 5'd0);

`ifdef DECODE_LOAD_USE_INTERLOCK_EN
    logic       r_sh_valid;
    logic [4:0] r_sh_rd;
    logic       w_uses_rs1, w_uses_rs2, w_held_ld, w_sh_live;
    logic       w_hit_held, w_hit_sh;

    assign w_uses_rs1 = (w_opcode != OP_JAL);
    assign w_uses_rs2 = (w_opcode == OP_RTYPE) | (w_opcode == OP_STORE) | (w_opcode == OP_BRANCH);
    // a load with rd != 0 is the only thing that writes both wb_sel=1 and reg_we
    assign w_held_ld  = r_valid & (r_wb_sel == 2'd1) & r_reg_we;
    // the shadow stops mattering in the cycle downstream moves on
    assign w_sh_live  = r_sh_valid & ~out_ready;
    assign w_hit_held = w_held_ld & ((w_uses_rs1 & (w_rs1 == r_rd)) | (w_uses_rs2 & (w_rs2 == r_rd)));
    assign w_hit_sh   = w_sh_live & ((w_uses_rs1 & (w_rs1 == r_sh_rd)) | (w_uses_rs2 & (w_rs2 == r_sh_rd)));
    assign w_hazard   = w_hit_held | w_hit_sh;

    // track a load that has left this stage but may still be stalled downstream
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sh_valid <= 1'b0;
            r_sh_rd    <= 5'd0;
        end else if (flush) begin
            r_sh_valid <= 1'b0;
        end else if (w_xfer && w_held_ld) begin
            r_sh_valid <= 1'b1;
            r_sh_rd    <= r_rd;
        end else if (out_ready) begin
            r_sh_valid <= 1'b0;
        end
    end
`else
    assign w_hazard = 1'b0;
`endif

    assign in_ready = (r_state == ST_RUN) & ~flush & ~w_hazard & (~r_valid | out_ready);
    assign w_accept = in_valid & in_ready;
    assign w_xfer   = r_valid & out_ready;

    // ID/EX output register: flush kills, accept loads, transfer leaves a bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_imm         <= {XLEN{1'b0}};
            r_rs1         <= 5'd0;
            r_rs2         <= 5'd0;
            r_rd          <= 5'd0;
            r_alu_op      <= 5'd0;
            r_alu_src_imm <= 1'b0;
            r_reg_we      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_branch      <= 1'b0;
            r_jump        <= 1'b0;
            r_jalr        <= 1'b0;
            r_halt        <= 1'b0;
            r_wb_sel      <= 2'd0;
            r_link_pc     <= {PC_W{1'b0}};
        end else if (flush) begin
            r_valid       <= 1'b0;
        end else if (w_accept) begin
            r_valid       <= 1'b1;
            r_imm         <= w_imm;
            r_rs1         <= w_rs1;
            r_rs2         <= w_rs2;
            r_rd          <= w_rd;
            r_alu_op      <= w_alu_op;
            r_alu_src_imm <= w_alu_src_imm;
            r_reg_we      <= w_reg_we;
            r_mem_we      <= w_mem_we;
            r_branch      <= w_branch;
            r_jump        <= w_jump;
            r_jalr        <= w_jalr;
            r_halt        <= w_halt;
            r_wb_sel      <= w_wb_sel;
            r_link_pc     <= w_link_pc;
        end else if (w_xfer) begin
            r_valid       <= 1'b0;
        end
    end

    // run/halted state machine; HALTED is sticky until reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_xfer && r_halt) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end else begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end
                end
                ST_HALTED: begin
                    r_state  <= ST_HALTED;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid        = r_valid;
    assign out_imm          = r_imm;
    assign out_rs1          = r_rs1;
    assign out_rs2          = r_rs2;
    assign out_rd           = r_rd;
    assign out_alu_op       = r_alu_op;
    assign out_alu_src_imm  = r_alu_src_imm;
    assign out_reg_wrenable = r_reg_we;
    assign out_mem_wrenable = r_mem_we;
    assign out_branch       = r_branch;
    assign out_jump         = r_jump;
    assign out_jalr         = r_jalr;
    assign out_halt         = r_halt;
    assign out_wb_sel       = r_wb_sel;
    assign out_link_pc      = r_link_pc;
    assign halted           = r_halted;

endmodule
